ddr3_cmd_arbiter: RTL and testbench
===================================

DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

Interface
REQ-001 Parameter: ADDR_W, 27, command address width.
REQ-002 Parameter: DATA_W, 128, write/read data width; mask width is DATA_W/8.
REQ-003 Parameter: TAG_DEPTH, 4, outstanding-read tag FIFO entries (power of two).
REQ-004 Ports: clk  in  1  single clock; rst  in  1  asynchronous, active-high reset.
REQ-005 Ports, per requester n in {0,1}: reqn_cmd_valid in 1; reqn_cmd_rdy out 1; reqn_cmd_type in 1 (0=write, 1=read); reqn_cmd_addr in ADDR_W; reqn_cmd_burst_cnt in 6; reqn_cmd_wt_data in DATA_W; reqn_cmd_wt_mask in DATA_W/8.
REQ-006 Ports, per requester n: reqn_rsp_valid out 1; reqn_rsp_rdy in 1; reqn_rsp_data out DATA_W.
REQ-007 Ports, bridge side: fifo_cmd_valid out 1; fifo_cmd_rdy in 1; fifo_cmd_type out 1; fifo_cmd_addr out ADDR_W; fifo_cmd_burst_cnt out 6; fifo_cmd_wt_data out DATA_W; fifo_cmd_wt_mask out DATA_W/8; fifo_rsp_valid in 1; fifo_rsp_rdy out 1; fifo_rsp_data in DATA_W.

Function
REQ-008 FSM states: IDLE, GRANT; one command transfer per handshake (valid & rdy same cycle).
REQ-009 IDLE: eligible = cmd_valid and (type=write or tag FIFO not full); if any eligible, latch grant index and go to GRANT next cycle.
REQ-010 Round-robin: priority pointer starts at req0; the requester not granted last has priority; pointer moves only on accepted command.
REQ-011 GRANT: fifo_cmd_* driven from granted requester's inputs; fifo_cmd_valid=1; granted reqn_cmd_rdy = fifo_cmd_rdy; other cmd_rdy=0.
REQ-012 GRANT exit: on fifo_cmd handshake, return to IDLE; minimum 2 cycles per command.
REQ-013 Requester shall hold cmd fields stable until handshake; arbiter never withdraws an asserted fifo_cmd_valid.
REQ-014 Accepted read pushes {id, burst_cnt} into tag FIFO the same cycle; writes push nothing.
REQ-015 Read returns burst_cnt+1 response beats, in command order.
REQ-016 Response routing: head tag selects requester; that reqn_rsp_valid = fifo_rsp_valid, reqn_rsp_data = fifo_rsp_data, fifo_rsp_rdy = reqn_rsp_rdy; other rsp_valid=0.
REQ-017 Tag FIFO empty: fifo_rsp_rdy=0, all rsp_valid=0.
REQ-018 Beat counter loads from head tag; decrements on each rsp handshake; at last beat tag pops same cycle.
REQ-019 Tag full: reads ineligible; writes still arbitrated; push and pop in same cycle on full FIFO not allowed (push blocked).
REQ-020 Simultaneous push and pop with FIFO neither full nor empty: both take effect, occupancy unchanged.

Reset
REQ-021 On rst: state=IDLE, pointer=req0, tag FIFO empty, beat counter=0.
REQ-022 Outputs during/after reset: fifo_cmd_valid=0, all cmd_rdy=0, fifo_rsp_rdy=0, all rsp_valid=0; data outputs don't-care.
REQ-023 Reset mid-transfer discards pending grant and outstanding tags; no reconciliation with bridge.

Structure
REQ-024 Shared package ddr3_arb_pkg: ADDR_W/DATA_W defaults, cmd-type constants CMD_WR=0/CMD_RD=1, FSM state enum, tag struct {id, burst_cnt}.
REQ-025 One sub-module ddr3_tag_fifo: synchronous FIFO, TAG_DEPTH deep, full/empty flags, async active-high reset.

Verification
REQ-026 Both requesters write continuously, fifo_cmd_rdy=1 -> grants alternate 0,1,0,1; one command per 2 cycles.
REQ-027 req0 read addr 0x100 burst_cnt=3, then req1 read burst_cnt=0 -> 4 beats to req0, then 1 beat to req1; rsp_valid on the other port stays 0.
REQ-028 5 reads issued, bridge withholds responses -> 4 accepted, 5th stalls with cmd_rdy=0; concurrent write from other port still accepted.
REQ-029 fifo_cmd_rdy held 0 for 10 cycles in GRANT -> fifo_cmd_valid and fields stable, no grant change.
REQ-030 rst asserted during GRANT with 2 tags outstanding -> next cycle all valid/rdy outputs 0, tag FIFO empty, next grant goes to req0.
REQ-031 reqn_rsp_rdy=0 for 3 cycles mid-burst -> fifo_rsp_rdy=0 for those cycles; beat count unchanged, no beat lost.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the two-port DDR3 command arbiter.
package ddr3_arb_pkg;

  localparam int DEF_ADDR_W = 27;
  localparam int DEF_DATA_W = 128;

  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One entry per accepted read: who asked, and how many beats minus one.
  typedef struct packed {
    logic       id;
    logic [5:0] burst_cnt;
  } tag_t;

endpackage

// File: rtl/ddr3_tag_fifo.sv
// Outstanding-read tag FIFO; a push while full is dropped, so a read is
// never accepted without a slot to remember where its data goes.
module ddr3_tag_fifo
  import ddr3_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  tag_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_tag;
  end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter of two command requesters onto one bridge port, with
// in-order routing of read response beats back to the requester that asked.
module ddr3_cmd_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_cmd_valid,
  output logic                req0_cmd_rdy,
  input  logic                req0_cmd_type,
  input  logic [ADDR_W-1:0]   req0_cmd_addr,
  input  logic [5:0]          req0_cmd_burst_cnt,
  input  logic [DATA_W-1:0]   req0_cmd_wt_data,
  input  logic [DATA_W/8-1:0] req0_cmd_wt_mask,
  output logic                req0_rsp_valid,
  input  logic                req0_rsp_rdy,
  output logic [DATA_W-1:0]   req0_rsp_data,
  input  logic                req1_cmd_valid,
  output logic                req1_cmd_rdy,
  input  logic                req1_cmd_type,
  input  logic [ADDR_W-1:0]   req1_cmd_addr,
  input  logic [5:0]          req1_cmd_burst_cnt,
  input  logic [DATA_W-1:0]   req1_cmd_wt_data,
  input  logic [DATA_W/8-1:0] req1_cmd_wt_mask,
  output logic                req1_rsp_valid,
  input  logic                req1_rsp_rdy,
  output logic [DATA_W-1:0]   req1_rsp_data,
  output logic                fifo_cmd_valid,
  input  logic                fifo_cmd_rdy,
  output logic                fifo_cmd_type,
  output logic [ADDR_W-1:0]   fifo_cmd_addr,
  output logic [5:0]          fifo_cmd_burst_cnt,
  output logic [DATA_W-1:0]   fifo_cmd_wt_data,
  output logic [DATA_W/8-1:0] fifo_cmd_wt_mask,
  input  logic                fifo_rsp_valid,
  output logic                fifo_rsp_rdy,
  input  logic [DATA_W-1:0]   fifo_rsp_data
);

  // Handshakes: a transfer happens in the cycle where valid and rdy are both
  // high; valid never drops before that, and rdy may depend on valid.
  arb_state_e state;
  logic       gnt;
  logic       ptr;
  logic       elig0;
  logic       elig1;
  logic       pick;
  logic       cmd_hs;
  tag_t       push_tag;
  tag_t       head;
  logic       tag_full;
  logic       tag_empty;
  logic       rsp_hs;
  logic       beat_active;
  logic [5:0] beat_cnt;
  logic [5:0] beats_left;
  logic       last_beat;

  assign elig0 = req0_cmd_valid && (req0_cmd_type == CMD_WR || !tag_full);
  assign elig1 = req1_cmd_valid && (req1_cmd_type == CMD_WR || !tag_full);
  assign pick  = (elig0 && elig1) ? ptr : elig1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            gnt   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (fifo_cmd_rdy) begin
            ptr   <= ~gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_cmd_valid = (state == GRANT);
  assign cmd_hs         = fifo_cmd_valid && fifo_cmd_rdy;
  assign req0_cmd_rdy   = fifo_cmd_valid && !gnt && fifo_cmd_rdy;
  assign req1_cmd_rdy   = fifo_cmd_valid && gnt && fifo_cmd_rdy;

  always_comb begin
    fifo_cmd_type      = req0_cmd_type;
    fifo_cmd_addr      = req0_cmd_addr;
    fifo_cmd_burst_cnt = req0_cmd_burst_cnt;
    fifo_cmd_wt_data   = req0_cmd_wt_data;
    fifo_cmd_wt_mask   = req0_cmd_wt_mask;
    if (gnt) begin
      fifo_cmd_type      = req1_cmd_type;
      fifo_cmd_addr      = req1_cmd_addr;
      fifo_cmd_burst_cnt = req1_cmd_burst_cnt;
      fifo_cmd_wt_data   = req1_cmd_wt_data;
      fifo_cmd_wt_mask   = req1_cmd_wt_mask;
    end
  end

  assign push_tag = '{id: gnt, burst_cnt: fifo_cmd_burst_cnt};

  ddr3_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_hs && fifo_cmd_type == CMD_RD),
    .push_tag (push_tag),
    .pop      (rsp_hs && last_beat),
    .head     (head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // The head tag owns the response channel until its last beat is taken.
  assign fifo_rsp_rdy   = !tag_empty && (head.id ? req1_rsp_rdy : req0_rsp_rdy);
  assign req0_rsp_valid = !tag_empty && !head.id && fifo_rsp_valid;
  assign req1_rsp_valid = !tag_empty && head.id && fifo_rsp_valid;
  assign req0_rsp_data  = fifo_rsp_data;
  assign req1_rsp_data  = fifo_rsp_data;
  assign rsp_hs         = fifo_rsp_valid && fifo_rsp_rdy;

  assign beats_left = beat_active ? beat_cnt : head.burst_cnt;
  assign last_beat  = (beats_left == 6'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_active <= 1'b0;
      beat_cnt    <= 6'd0;
    end else if (rsp_hs) begin
      if (last_beat) begin
        beat_active <= 1'b0;
        beat_cnt    <= 6'd0;
      end else begin
        beat_active <= 1'b1;
        beat_cnt    <= beats_left - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Bench for ddr3_cmd_arbiter: arbitration table plus hand-written read,
// backpressure, tag-full and reset sequences, all checked via scoreboards.
module tb_ddr3_cmd_arbiter;
  localparam int AW = 27;
  localparam int DW = 128;
  localparam int MW = DW / 8;
  localparam int SW = 2 + 1 + 6 + AW + MW + 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_cmd_valid, req0_cmd_rdy, req0_cmd_type;
  logic [AW-1:0] req0_cmd_addr;
  logic [5:0]    req0_cmd_burst_cnt;
  logic [DW-1:0] req0_cmd_wt_data;
  logic [MW-1:0] req0_cmd_wt_mask;
  logic          req0_rsp_valid, req0_rsp_rdy;
  logic [DW-1:0] req0_rsp_data;
  logic          req1_cmd_valid, req1_cmd_rdy, req1_cmd_type;
  logic [AW-1:0] req1_cmd_addr;
  logic [5:0]    req1_cmd_burst_cnt;
  logic [DW-1:0] req1_cmd_wt_data;
  logic [MW-1:0] req1_cmd_wt_mask;
  logic          req1_rsp_valid, req1_rsp_rdy;
  logic [DW-1:0] req1_rsp_data;
  logic          fifo_cmd_valid, fifo_cmd_rdy, fifo_cmd_type;
  logic [AW-1:0] fifo_cmd_addr;
  logic [5:0]    fifo_cmd_burst_cnt;
  logic [DW-1:0] fifo_cmd_wt_data;
  logic [MW-1:0] fifo_cmd_wt_mask;
  logic          fifo_rsp_valid, fifo_rsp_rdy;
  logic [DW-1:0] fifo_rsp_data;

  int total = 0;
  int bad   = 0;

  logic [SW-1:0] exp_q[$];
  logic [DW-1:0] rq0[$];
  logic [DW-1:0] rq1[$];
  logic [DW-1:0] cur_data [2];
  logic [MW-1:0] cur_mask [2];

  ddr3_cmd_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_cmd_valid(req0_cmd_valid), .req0_cmd_rdy(req0_cmd_rdy),
    .req0_cmd_type(req0_cmd_type), .req0_cmd_addr(req0_cmd_addr),
    .req0_cmd_burst_cnt(req0_cmd_burst_cnt), .req0_cmd_wt_data(req0_cmd_wt_data),
    .req0_cmd_wt_mask(req0_cmd_wt_mask), .req0_rsp_valid(req0_rsp_valid),
    .req0_rsp_rdy(req0_rsp_rdy), .req0_rsp_data(req0_rsp_data),
    .req1_cmd_valid(req1_cmd_valid), .req1_cmd_rdy(req1_cmd_rdy),
    .req1_cmd_type(req1_cmd_type), .req1_cmd_addr(req1_cmd_addr),
    .req1_cmd_burst_cnt(req1_cmd_burst_cnt), .req1_cmd_wt_data(req1_cmd_wt_data),
    .req1_cmd_wt_mask(req1_cmd_wt_mask), .req1_rsp_valid(req1_rsp_valid),
    .req1_rsp_rdy(req1_rsp_rdy), .req1_rsp_data(req1_rsp_data),
    .fifo_cmd_valid(fifo_cmd_valid), .fifo_cmd_rdy(fifo_cmd_rdy),
    .fifo_cmd_type(fifo_cmd_type), .fifo_cmd_addr(fifo_cmd_addr),
    .fifo_cmd_burst_cnt(fifo_cmd_burst_cnt), .fifo_cmd_wt_data(fifo_cmd_wt_data),
    .fifo_cmd_wt_mask(fifo_cmd_wt_mask), .fifo_rsp_valid(fifo_rsp_valid),
    .fifo_rsp_rdy(fifo_rsp_rdy), .fifo_rsp_data(fifo_rsp_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Command scoreboard: every bridge-side handshake must match the next expectation
  always @(negedge clk) begin
    if (!rst && fifo_cmd_valid && fifo_cmd_rdy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL cmd_unexpected: got addr %0h with no expectation", fifo_cmd_addr);
      end else begin
        chk("cmd", {req1_cmd_rdy, req0_cmd_rdy, fifo_cmd_type, fifo_cmd_burst_cnt,
                    fifo_cmd_addr, fifo_cmd_wt_mask, fifo_cmd_wt_data[31:0]},
            exp_q.pop_front());
      end
    end
  end

  // Response scoreboards, one per requester
  always @(negedge clk) begin
    if (!rst && req0_rsp_valid && req0_rsp_rdy) begin
      if (rq0.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp0_unexpected: got %0h", req0_rsp_data);
      end else chk("rsp0_data", req0_rsp_data, rq0.pop_front());
    end
    if (!rst && req1_rsp_valid && req1_rsp_rdy) begin
      if (rq1.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp1_unexpected: got %0h", req1_rsp_data);
      end else chk("rsp1_data", req1_rsp_data, rq1.pop_front());
    end
  end

  // Driver tasks
  task automatic set_req(input int n, input logic v, input logic t,
                         input logic [AW-1:0] a, input logic [5:0] b);
    cur_data[n] = {$urandom(), $urandom(), $urandom(), $urandom()};
    cur_mask[n] = MW'($urandom_range(0, 65535));
    if (n == 0) begin
      req0_cmd_valid = v; req0_cmd_type = t; req0_cmd_addr = a;
      req0_cmd_burst_cnt = b; req0_cmd_wt_data = cur_data[0]; req0_cmd_wt_mask = cur_mask[0];
    end else begin
      req1_cmd_valid = v; req1_cmd_type = t; req1_cmd_addr = a;
      req1_cmd_burst_cnt = b; req1_cmd_wt_data = cur_data[1]; req1_cmd_wt_mask = cur_mask[1];
    end
  endtask

  task automatic push_cmd(input int n, input logic t, input logic [AW-1:0] a, input logic [5:0] b);
    exp_q.push_back({(n == 1), (n == 0), t, b, a, cur_mask[n], cur_data[n][31:0]});
  endtask

  task automatic wait_cmd(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(fifo_cmd_valid && fifo_cmd_rdy) && cyc < 20);
    if (!(fifo_cmd_valid && fifo_cmd_rdy)) begin
      total++; bad++;
      $display("FAIL %s: no command handshake within %0d cycles", name, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input int n, input logic [DW-1:0] d);
    int cyc;
    cyc = 0;
    fifo_rsp_valid = 1'b1;
    fifo_rsp_data  = d;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fifo_rsp_rdy && cyc < 20);
    chk("beat_accept", fifo_rsp_rdy, 1);
    chk("beat_own_valid", (n == 0) ? req0_rsp_valid : req1_rsp_valid, 1);
    chk("beat_other_valid", (n == 0) ? req1_rsp_valid : req0_rsp_valid, 0);
    @(posedge clk); #1;
    fifo_rsp_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_cmd_valid"}, fifo_cmd_valid, 0);
    chk({name, "_req0_cmd_rdy"}, req0_cmd_rdy, 0);
    chk({name, "_req1_cmd_rdy"}, req1_cmd_rdy, 0);
    chk({name, "_fifo_rsp_rdy"}, fifo_rsp_rdy, 0);
    chk({name, "_req0_rsp_valid"}, req0_rsp_valid, 0);
    chk({name, "_req1_rsp_valid"}, req1_rsp_valid, 0);
  endtask

  typedef struct {
    logic v0;
    logic v1;
    logic gnt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int            cyc;
    logic [DW-1:0] d [4];
    logic [AW-1:0] a;

    vecs[0] = '{1, 1, 0}; vecs[1] = '{1, 1, 1}; vecs[2] = '{1, 1, 0};
    vecs[3] = '{1, 1, 1}; vecs[4] = '{0, 1, 1}; vecs[5] = '{0, 1, 1};
    vecs[6] = '{1, 1, 0}; vecs[7] = '{1, 0, 0}; vecs[8] = '{1, 1, 1};

    rst = 1'b1;
    fifo_cmd_rdy = 1'b1; fifo_rsp_valid = 1'b0; fifo_rsp_data = '0;
    req0_rsp_rdy = 1'b1; req1_rsp_rdy = 1'b1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);

    // Reset state, during and right after reset
    fifo_rsp_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_reset");
    @(posedge clk); #1;
    fifo_rsp_valid = 1'b0;

    // Arbitration table: writes only, one command every 2 cycles
    for (int i = 0; i < 9; i++) begin
      set_req(0, vecs[i].v0, 0, AW'(32'h1000 + i), 6'(i));
      set_req(1, vecs[i].v1, 0, AW'(32'h2000 + i), 6'(i + 1));
      a = vecs[i].gnt ? AW'(32'h2000 + i) : AW'(32'h1000 + i);
      push_cmd(vecs[i].gnt, 0, a, vecs[i].gnt ? 6'(i + 1) : 6'(i));
      wait_cmd("table", cyc);
      chk("table_latency", cyc, 2);
    end
    req0_cmd_valid = 1'b0; req1_cmd_valid = 1'b0;

    // Read burst of 4 to req0, then a single-beat read to req1
    set_req(0, 1, 1, AW'(32'h100), 6'd3);
    push_cmd(0, 1, AW'(32'h100), 6'd3);
    wait_cmd("rd0", cyc);
    req0_cmd_valid = 1'b0;
    set_req(1, 1, 1, AW'(32'h200), 6'd0);
    push_cmd(1, 1, AW'(32'h200), 6'd0);
    wait_cmd("rd1", cyc);
    req1_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      rq0.push_back(d[i]);
      send_beat(0, d[i]);
    end
    d[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    rq1.push_back(d[0]);
    send_beat(1, d[0]);
    fifo_rsp_valid = 1'b1;
    @(negedge clk);
    chk("empty_rsp_rdy", fifo_rsp_rdy, 0);
    chk("empty_rsp0_valid", req0_rsp_valid, 0);
    chk("empty_rsp1_valid", req1_rsp_valid, 0);
    @(posedge clk); #1;
    fifo_rsp_valid = 1'b0;

    // Requester backpressure for 3 cycles in the middle of a burst
    set_req(0, 1, 1, AW'(32'h300), 6'd3);
    push_cmd(0, 1, AW'(32'h300), 6'd3);
    wait_cmd("rd_bp", cyc);
    req0_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      rq0.push_back(d[i]);
    end
    send_beat(0, d[0]);
    req0_rsp_rdy = 1'b0;
    fifo_rsp_valid = 1'b1;
    fifo_rsp_data = d[1];
    repeat (3) begin
      @(negedge clk);
      chk("bp_fifo_rsp_rdy", fifo_rsp_rdy, 0);
      chk("bp_rsp0_valid", req0_rsp_valid, 1);
      @(posedge clk); #1;
    end
    req0_rsp_rdy = 1'b1;
    for (int i = 1; i < 4; i++) send_beat(0, d[i]);
    chk("bp_rq0_drained", rq0.size(), 0);
    fifo_rsp_valid = 1'b1;
    @(negedge clk);
    chk("bp_after_rsp_rdy", fifo_rsp_rdy, 0);
    @(posedge clk); #1;
    fifo_rsp_valid = 1'b0;

    // Fill the tag FIFO with responses withheld; a 5th read must stall
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 1, AW'(32'h400 + i), 6'd0);
      push_cmd(0, 1, AW'(32'h400 + i), 6'd0);
      wait_cmd("fill", cyc);
      req0_cmd_valid = 1'b0;
    end
    set_req(0, 1, 1, AW'(32'h480), 6'd0);
    repeat (6) begin
      @(negedge clk);
      chk("full_cmd_valid", fifo_cmd_valid, 0);
      chk("full_req0_rdy", req0_cmd_rdy, 0);
    end
    @(posedge clk); #1;
    set_req(1, 1, 0, AW'(32'h2480), 6'd5);
    push_cmd(1, 0, AW'(32'h2480), 6'd5);
    wait_cmd("full_write", cyc);
    req1_cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("full_still_stalled", fifo_cmd_valid, 0);
    end
    @(posedge clk); #1;
    req0_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      rq0.push_back(d[i]);
    end
    for (int i = 0; i < 3; i++) send_beat(0, d[i]);
    set_req(0, 1, 1, AW'(32'h480), 6'd0);
    push_cmd(0, 1, AW'(32'h480), 6'd0);
    wait_cmd("fifth_read", cyc);
    req0_cmd_valid = 1'b0;

    // Bridge stall in GRANT (pointer favours req1), then reset with 2 tags outstanding
    fifo_cmd_rdy = 1'b0;
    set_req(0, 1, 0, AW'(32'h1500), 6'd2);
    set_req(1, 1, 0, AW'(32'h2500), 6'd4);
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", fifo_cmd_valid, 1);
      chk("stall_addr", fifo_cmd_addr, AW'(32'h2500));
      chk("stall_data", fifo_cmd_wt_data, cur_data[1]);
      chk("stall_rdy", {req1_cmd_rdy, req0_cmd_rdy}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    fifo_rsp_valid = 1'b1;
    rq0.delete();
    rq1.delete();
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    @(posedge clk); #1;
    fifo_cmd_rdy = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_tags_empty", fifo_rsp_rdy, 0);
    chk("post_reset_rsp0_valid", req0_rsp_valid, 0);
    @(posedge clk); #1;
    fifo_rsp_valid = 1'b0;
    // 1 cycle of IDLE already elapsed, so the first grant completes one edge later
    push_cmd(0, 0, AW'(32'h1500), 6'd2);
    push_cmd(1, 0, AW'(32'h2500), 6'd4);
    wait_cmd("post_reset_gnt0", cyc);
    chk("post_reset_latency", cyc, 1);
    wait_cmd("post_reset_gnt1", cyc);
    chk("post_reset_alt_latency", cyc, 2);
    req0_cmd_valid = 1'b0; req1_cmd_valid = 1'b0;

    repeat (3) @(posedge clk);
    chk("cmd_queue_empty", exp_q.size(), 0);
    chk("rsp_queues_empty", rq0.size() + rq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
